// File: rtl/tile_layer_gpu.sv
// Multi-layer scrolling tile-map renderer: map fetch, texel fetch, then priority compositing.
// Four-stage pipeline; the sync/blank signals go through four flops so they stay aligned with rgb_out.
module tile_layer_gpu #(
    parameter int unsigned TILE_LOG2     = 5,
    parameter int unsigned MAP_COLS_LOG2 = 5,
    parameter int unsigned MAP_ROWS_LOG2 = 5,
    parameter int unsigned TEX_LOG2      = 3,
    parameter int unsigned LAYERS        = 2,
    parameter logic [11:0] KEY_COLOR     = 12'hF0F,
    parameter logic [11:0] BG_COLOR      = 12'h000
) (
    input  logic                   vga_clk,
    input  logic                   rst,
    input  logic [10:0]            hcount_in,
    input  logic [10:0]            vcount_in,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic                   hblank_in,
    input  logic                   vblank_in,
    input  logic [LAYERS*11-1:0]   scroll_x,
    input  logic [LAYERS*11-1:0]   scroll_y,
    output logic [LAYERS*32-1:0]   map_addr,
    input  logic [LAYERS*32-1:0]   map_rdata,
    output logic [LAYERS*32-1:0]   tex_addr,
    input  logic [LAYERS*32-1:0]   tex_rdata,
    output logic                   map_en,
    output logic                   tex_en,
    output logic [3:0]             map_we,
    output logic [3:0]             tex_we,
    output logic                   hsync_out,
    output logic                   vsync_out,
    output logic                   hblank_out,
    output logic                   vblank_out,
    output logic [11:0]            rgb_out,
    output logic                   frame_start
);

    localparam int unsigned PX_W      = TILE_LOG2 + MAP_COLS_LOG2;
    localparam int unsigned PY_W      = TILE_LOG2 + MAP_ROWS_LOG2;
    localparam int unsigned MAP_IDX_W = MAP_ROWS_LOG2 + MAP_COLS_LOG2;
    localparam int unsigned TEX_IDX_W = TEX_LOG2 + 2 * TILE_LOG2;

    logic [10:0]           sx_q      [LAYERS];
    logic [10:0]           sy_q      [LAYERS];
    logic [TILE_LOG2-1:0]  px_lo_q   [LAYERS];
    logic [TILE_LOG2-1:0]  py_lo_q   [LAYERS];
    logic [11:0]           texel_q   [LAYERS];
    logic [LAYERS-1:0]     en1_q;
    logic [LAYERS-1:0]     en2_q;
    logic                  vsync_prev_q;
    logic [3:0]            hsync_d_q;
    logic [3:0]            vsync_d_q;
    logic [3:0]            hblank_d_q;
    logic [3:0]            vblank_d_q;

    logic [PX_W-1:0]       px_c      [LAYERS];
    logic [PY_W-1:0]       py_c      [LAYERS];
    logic [MAP_IDX_W-1:0]  map_idx_c [LAYERS];
    logic [TILE_LOG2-1:0]  tx_c      [LAYERS];
    logic [TILE_LOG2-1:0]  ty_c      [LAYERS];
    logic [TEX_IDX_W-1:0]  tex_idx_c [LAYERS];
    logic [11:0]           pix_c;
    logic                  vsync_rise_c;
    logic                  unused_rdata_c;

    assign map_en = 1'b1;
    assign tex_en = 1'b1;
    assign map_we = 4'h0;
    assign tex_we = 4'h0;

    assign hsync_out  = hsync_d_q[3];
    assign vsync_out  = vsync_d_q[3];
    assign hblank_out = hblank_d_q[3];
    assign vblank_out = vblank_d_q[3];

    assign vsync_rise_c = vsync_in & ~vsync_prev_q;

    // Only the entry fields and the low 12 texel bits carry meaning; the rest of each word is ignored.
    assign unused_rdata_c = ^{map_rdata, tex_rdata};

    // Stage 0 wrapped pixel coordinates and stage 1 flipped texel coordinates.
    always_comb begin
        for (int n = 0; n < LAYERS; n++) begin
            px_c[n]      = PX_W'(hcount_in + sx_q[n]);
            py_c[n]      = PY_W'(vcount_in + sy_q[n]);
            map_idx_c[n] = {py_c[n][PY_W-1:TILE_LOG2], px_c[n][PX_W-1:TILE_LOG2]};
            tx_c[n]      = map_rdata[32*n + 15] ? ~px_lo_q[n] : px_lo_q[n];
            ty_c[n]      = map_rdata[32*n + 14] ? ~py_lo_q[n] : py_lo_q[n];
            tex_idx_c[n] = {map_rdata[32*n +: TEX_LOG2], ty_c[n], tx_c[n]};
        end
    end

    // Highest-index opaque, enabled layer wins.
    always_comb begin
        pix_c = BG_COLOR;
        for (int n = 0; n < LAYERS; n++) begin
            if (en2_q[n] && (texel_q[n] != KEY_COLOR)) begin
                pix_c = texel_q[n];
            end
        end
    end

    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            vsync_prev_q <= 1'b0;
            frame_start  <= 1'b0;
            map_addr     <= '0;
            tex_addr     <= '0;
            en1_q        <= '0;
            en2_q        <= '0;
            for (int n = 0; n < LAYERS; n++) begin
                sx_q[n]    <= '0;
                sy_q[n]    <= '0;
                px_lo_q[n] <= '0;
                py_lo_q[n] <= '0;
                texel_q[n] <= '0;
            end
            hsync_d_q  <= '0;
            vsync_d_q  <= '0;
            hblank_d_q <= '1;
            vblank_d_q <= '1;
            rgb_out    <= '0;
        end else begin
            vsync_prev_q <= vsync_in;
            frame_start  <= vsync_rise_c;
            for (int n = 0; n < LAYERS; n++) begin
                // The latch edge still renders with the old scroll; the new value applies from the next pixel.
                if (vsync_rise_c) begin
                    sx_q[n] <= scroll_x[11*n +: 11];
                    sy_q[n] <= scroll_y[11*n +: 11];
                end
                map_addr[32*n +: 32] <= 32'({map_idx_c[n], 2'b00});
                px_lo_q[n]           <= px_c[n][TILE_LOG2-1:0];
                py_lo_q[n]           <= py_c[n][TILE_LOG2-1:0];
                tex_addr[32*n +: 32] <= 32'({tex_idx_c[n], 2'b00});
                en1_q[n]             <= map_rdata[32*n + 13];
                texel_q[n]           <= tex_rdata[32*n +: 12];
                en2_q[n]             <= en1_q[n];
            end
            hsync_d_q  <= {hsync_d_q[2:0], hsync_in};
            vsync_d_q  <= {vsync_d_q[2:0], vsync_in};
            hblank_d_q <= {hblank_d_q[2:0], hblank_in};
            vblank_d_q <= {vblank_d_q[2:0], vblank_in};
            rgb_out    <= (hblank_d_q[2] | vblank_d_q[2]) ? 12'h000 : pix_c;
        end
    end

endmodule

// File: tb/tb_tile_layer_gpu.sv
// Scoreboard bench for tile_layer_gpu: a reference model predicts every pixel when it is driven,
// and the prediction is popped and compared when it reaches the outputs.
module tb_tile_layer_gpu;

    logic        vga_clk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblank_in, vblank_in;
    logic [21:0] scroll_x, scroll_y;
    logic [63:0] map_addr, map_rdata, tex_addr, tex_rdata;
    logic        map_en, tex_en;
    logic [3:0]  map_we, tex_we;
    logic        hsync_out, vsync_out, hblank_out, vblank_out;
    logic [11:0] rgb_out;
    logic        frame_start;

    logic [15:0] map_mem [2][1024];
    logic [11:0] tex_mem [2][8192];

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs, vs, hb, vb;
        logic [63:0] ma, ta;
    } exp_t;

    exp_t        sb_q[$];
    logic [10:0] msx [2];
    logic [10:0] msy [2];
    logic        m_vs_prev;
    int          n_checks = 0;
    int          n_pass   = 0;

    tile_layer_gpu dut (
        .vga_clk(vga_clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblank_in(hblank_in), .vblank_in(vblank_in),
        .scroll_x(scroll_x), .scroll_y(scroll_y),
        .map_addr(map_addr), .map_rdata(map_rdata),
        .tex_addr(tex_addr), .tex_rdata(tex_rdata),
        .map_en(map_en), .tex_en(tex_en), .map_we(map_we), .tex_we(tex_we),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblank_out(hblank_out), .vblank_out(vblank_out),
        .rgb_out(rgb_out), .frame_start(frame_start)
    );

    always #5 vga_clk = ~vga_clk;

    // BRAM models; the address register lives in the DUT. Upper word bits carry junk that must be ignored.
    assign map_rdata = {16'hBEEF, map_mem[1][map_addr[43:34]], 16'hCAFE, map_mem[0][map_addr[11:2]]};
    assign tex_rdata = {20'hABCDE, tex_mem[1][tex_addr[46:34]], 20'h12345, tex_mem[0][tex_addr[14:2]]};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [10:0] h, input logic [10:0] v,
                                   input logic hs, input logic vs, input logic hb, input logic vb);
        exp_t        e;
        logic [10:0] hsum, vsum;
        logic [9:0]  px, py, mi;
        logic [15:0] ent;
        logic [4:0]  tx, ty;
        logic [12:0] ti;
        logic [11:0] t, res;
        res  = 12'h000;
        e.ma = '0;
        e.ta = '0;
        for (int l = 0; l < 2; l++) begin
            hsum = h + msx[l];
            vsum = v + msy[l];
            px   = hsum[9:0];
            py   = vsum[9:0];
            mi   = {py[9:5], px[9:5]};
            e.ma[32*l +: 32] = {20'd0, mi, 2'b00};
            ent  = map_mem[l][mi];
            tx   = ent[15] ? ~px[4:0] : px[4:0];
            ty   = ent[14] ? ~py[4:0] : py[4:0];
            ti   = {ent[2:0], ty, tx};
            e.ta[32*l +: 32] = {17'd0, ti, 2'b00};
            t    = tex_mem[l][ti];
            if (ent[13] && (t != 12'hF0F)) res = t;
        end
        e.rgb = (hb || vb) ? 12'h000 : res;
        e.hs  = hs;
        e.vs  = vs;
        e.hb  = hb;
        e.vb  = vb;
        return e;
    endfunction

    // One pixel clock: drive at the falling edge, predict, then check what is due at the next falling edge.
    task automatic drive(input logic [10:0] h, input logic [10:0] v,
                         input logic hs, input logic vs, input logic hb, input logic vb);
        exp_t e;
        logic rise;
        hcount_in = h;
        vcount_in = v;
        hsync_in  = hs;
        vsync_in  = vs;
        hblank_in = hb;
        vblank_in = vb;
        sb_q.push_back(model(h, v, hs, vs, hb, vb));
        rise = vs && !m_vs_prev;
        @(posedge vga_clk);
        m_vs_prev = vs;
        if (rise) begin
            for (int l = 0; l < 2; l++) begin
                msx[l] = scroll_x[11*l +: 11];
                msy[l] = scroll_y[11*l +: 11];
            end
        end
        @(negedge vga_clk);
        check("frame_start", 64'(frame_start), 64'(rise));
        check("map_addr", map_addr, sb_q[$].ma);
        if (sb_q.size() >= 2) check("tex_addr", tex_addr, sb_q[sb_q.size()-2].ta);
        if (sb_q.size() == 4) begin
            e = sb_q.pop_front();
            check("rgb_out", 64'(rgb_out), 64'(e.rgb));
            check("hsync_out", 64'(hsync_out), 64'(e.hs));
            check("vsync_out", 64'(vsync_out), 64'(e.vs));
            check("hblank_out", 64'(hblank_out), 64'(e.hb));
            check("vblank_out", 64'(vblank_out), 64'(e.vb));
        end
    endtask

    task automatic drive_px(input logic [10:0] h, input logic [10:0] v);
        drive(h, v, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Drive a pixel plus three followers so the first one is at rgb_out on return.
    task automatic probe(input logic [10:0] h, input logic [10:0] v);
        for (int i = 0; i < 4; i++) drive_px(11'(h + 11'(i)), v);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rgb"}, 64'(rgb_out), 64'(12'h000));
        check({tag, "_hsync"}, 64'(hsync_out), 64'(1'b0));
        check({tag, "_vsync"}, 64'(vsync_out), 64'(1'b0));
        check({tag, "_hblank"}, 64'(hblank_out), 64'(1'b1));
        check({tag, "_vblank"}, 64'(vblank_out), 64'(1'b1));
        check({tag, "_fs"}, 64'(frame_start), 64'(1'b0));
        check({tag, "_map_addr"}, map_addr, 64'd0);
        check({tag, "_tex_addr"}, tex_addr, 64'd0);
    endtask

    task automatic model_reset();
        for (int l = 0; l < 2; l++) begin
            msx[l] = '0;
            msy[l] = '0;
        end
        m_vs_prev = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        // Rows 0-6 hold directed tiles; the rest is random. Texture 5 is a position gradient.
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < 8192; i++) begin
                tex_mem[l][i] = ($urandom_range(0, 3) == 0) ? 12'hF0F : 12'($urandom);
                case (i / 1024)
                    1: tex_mem[l][i] = 12'h0F0;
                    2: tex_mem[l][i] = 12'hF0F;
                    3: tex_mem[l][i] = 12'h00F;
                    4: tex_mem[l][i] = 12'hF00;
                    5: tex_mem[l][i] = 12'(12'h800 | (i % 1024));
                    default: ;
                endcase
            end
        end
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 32; c++) begin
                case (r)
                    0: begin map_mem[0][r*32+c] = 16'h2001; map_mem[1][r*32+c] = 16'h0004; end
                    1: begin map_mem[0][r*32+c] = 16'h2003; map_mem[1][r*32+c] = 16'h2002; end
                    2: begin map_mem[0][r*32+c] = 16'h2003; map_mem[1][r*32+c] = 16'h2004; end
                    3: begin map_mem[0][r*32+c] = 16'h0003; map_mem[1][r*32+c] = 16'h0004; end
                    4: begin map_mem[0][r*32+c] = 16'hA005; map_mem[1][r*32+c] = 16'h0000; end
                    5: begin map_mem[0][r*32+c] = 16'h6005; map_mem[1][r*32+c] = 16'h0000; end
                    6: begin map_mem[0][r*32+c] = 16'hE005; map_mem[1][r*32+c] = 16'h0000; end
                    default: begin
                        map_mem[0][r*32+c] = 16'($urandom);
                        map_mem[1][r*32+c] = 16'($urandom);
                    end
                endcase
            end
        end

        rst = 1'b0;
        hcount_in = '0; vcount_in = '0;
        hsync_in = 1'b0; vsync_in = 1'b0; hblank_in = 1'b1; vblank_in = 1'b1;
        scroll_x = '0; scroll_y = '0;
        model_reset();
        repeat (3) @(negedge vga_clk);
        check_reset_values("reset");
        check("map_en", 64'(map_en), 64'(1'b1));
        check("tex_we", 64'(tex_we), 64'(4'h0));
        rst = 1'b1;

        // Frame start with zero scroll.
        drive(11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Single green tile at the origin, hsync aligned.
        drive(11'd0, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_px(11'd1, 11'd0);
        drive_px(11'd2, 11'd0);
        drive_px(11'd3, 11'd0);
        check("origin_rgb", 64'(rgb_out), 64'(12'h0F0));
        check("origin_hsync", 64'(hsync_out), 64'(1'b1));

        // Layer priority, colour key and disable.
        probe(11'd0, 11'd32);
        check("key_top", 64'(rgb_out), 64'(12'h00F));
        probe(11'd40, 11'd64);
        check("top_opaque", 64'(rgb_out), 64'(12'hF00));
        probe(11'd80, 11'd96);
        check("both_disabled", 64'(rgb_out), 64'(12'h000));

        // Flips at tile-local (0,0).
        drive_px(11'd0, 11'd128);
        drive_px(11'd1, 11'd128);
        check("hflip_tex_addr", 64'(tex_addr[31:0]), 64'(32'h507C));
        drive_px(11'd0, 11'd160);
        drive_px(11'd1, 11'd160);
        check("vflip_tex_addr", 64'(tex_addr[31:0]), 64'(32'h5F80));
        probe(11'd7, 11'd199);

        // Horizontal wrap with scroll_x = 5.
        scroll_x = {11'd0, 11'd5};
        drive(11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("fs_pulse", 64'(frame_start), 64'(1'b1));
        drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("fs_single", 64'(frame_start), 64'(1'b0));
        drive_px(11'd1023, 11'd0);
        check("wrap_map_addr", 64'(map_addr[31:0]), 64'd0);
        drive_px(11'd1024, 11'd0);
        drive_px(11'd1025, 11'd0);
        drive_px(11'd1026, 11'd0);
        check("wrap_rgb", 64'(rgb_out), 64'(12'h0F0));

        // scroll_y changes mid-frame only after the next vsync rise.
        scroll_y = {11'd0, 11'd32};
        probe(11'd0, 11'd0);
        check("scroll_hold", 64'(rgb_out), 64'(12'h0F0));
        drive(11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        probe(11'd0, 11'd0);
        check("scroll_applied", 64'(rgb_out), 64'(12'h00F));

        // Blanking forces black over an opaque tile.
        drive(11'd0, 11'd32, 1'b0, 1'b0, 1'b1, 1'b0);
        drive_px(11'd1, 11'd32);
        drive_px(11'd2, 11'd32);
        drive_px(11'd3, 11'd32);
        check("hblank_black", 64'(rgb_out), 64'(12'h000));

        // Asynchronous reset mid-line with pixels in flight.
        drive(11'd10, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(11'd11, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(11'd12, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(11'd13, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1 check_reset_values("midreset");
        model_reset();
        @(negedge vga_clk);
        @(negedge vga_clk);
        rst = 1'b1;
        probe(11'd0, 11'd32);
        check("post_reset_scroll0", 64'(rgb_out), 64'(12'h00F));

        // Random traffic with periodic frame starts and unlatched scroll changes.
        for (int i = 0; i < 240; i++) begin
            if (i % 60 == 0) begin
                scroll_x = 22'($urandom);
                scroll_y = 22'($urandom);
                drive(11'($urandom), 11'($urandom), 1'b0, 1'b1, 1'b1, 1'b1);
            end else begin
                if (i % 17 == 0) begin
                    scroll_x = 22'($urandom);
                    scroll_y = 22'($urandom);
                end
                drive(11'($urandom), 11'($urandom), 1'($urandom_range(0, 1)), 1'b0,
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
            end
        end
        repeat (4) drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tile_layer_gpu.md
TILE_LAYER_GPU -- requirements
Module: tile_layer_gpu

Interface
REQ-001 Parameter TILE_LOG2, default 5: tile edge = 2^TILE_LOG2 pixels.
REQ-002 Parameter MAP_COLS_LOG2, default 5: map width = 2^MAP_COLS_LOG2 tiles.
REQ-003 Parameter MAP_ROWS_LOG2, default 5: map height = 2^MAP_ROWS_LOG2 tiles.
REQ-004 Parameter TEX_LOG2, default 3: texture count = 2^TEX_LOG2.
REQ-005 Parameter LAYERS, default 2, legal 1..4: layer count; layer LAYERS-1 is topmost.
REQ-006 Parameter KEY_COLOR, default 12'hF0F: transparent texel value.
REQ-007 Parameter BG_COLOR, default 12'h000: colour shown where no layer is opaque.
REQ-008 vga_clk  in  1  pixel clock, all logic rising-edge.
REQ-009 rst  in  1  asynchronous, active-low reset.
REQ-010 hcount_in, vcount_in  in  11 each  pixel position from timing generator.
REQ-011 hsync_in, vsync_in, hblank_in, vblank_in  in  1 each  timing from generator.
REQ-012 scroll_x, scroll_y  in  LAYERS*11 each  per-layer pixel scroll, layer n at bits [11n+10:11n].
REQ-013 map_addr  out  LAYERS*32  per-layer map BRAM byte address; map_rdata  in  LAYERS*32.
REQ-014 tex_addr  out  LAYERS*32  per-layer texture BRAM byte address; tex_rdata  in  LAYERS*32.
REQ-015 map_en, tex_en  out  1 each  constant 1; map_we, tex_we  out  4 each  constant 0.
REQ-016 hsync_out, vsync_out, hblank_out, vblank_out  out  1 each  delayed timing.
REQ-017 rgb_out  out  12  {r,g,b} 4 bits each.
REQ-018 frame_start  out  1  one-cycle pulse when scroll registers are latched.

Function
REQ-019 Both BRAMs SHALL be treated as 1-cycle synchronous read; addresses registered in module.
REQ-020 Scroll inputs SHALL be latched into internal registers on the vga_clk edge where vsync_in rises (0->1); frame_start SHALL pulse high that same following cycle only.
REQ-021 Per layer, stage 0: px = (hcount_in + sx) mod (2^(TILE_LOG2+MAP_COLS_LOG2)), py = (vcount_in + sy) mod (2^(TILE_LOG2+MAP_ROWS_LOG2)); wrap-around SHALL be by truncation.
REQ-022 Stage 0 map_addr SHALL be ((py>>TILE_LOG2)*2^MAP_COLS_LOG2 + (px>>TILE_LOG2)) << 2, upper bits zero; registered.
REQ-023 Map entry format (map_rdata[15:0]): [TEX_LOG2-1:0] texture index, [13] enable, [14] vflip, [15] hflip; bits [31:16] ignored.
REQ-024 Stage 1: entry and px/py low TILE_LOG2 bits SHALL be registered; tx = hflip ? ~px_lo : px_lo, ty = vflip ? ~py_lo : py_lo.
REQ-025 Stage 1 tex_addr SHALL be ({tex_index, ty, tx}) << 2, upper bits zero; registered.
REQ-026 Stage 2: texel = tex_rdata[11:0] registered with enable bit delayed to match.
REQ-027 Stage 3 compositing: rgb = texel of highest-index layer with enable=1 and texel != KEY_COLOR; otherwise BG_COLOR.
REQ-028 rgb_out SHALL be 12'h000 when the delayed hblank or vblank is 1.
REQ-029 Total latency inputs -> rgb_out/sync outputs SHALL be exactly 4 cycles; all four timing signals delayed by 4 flops so alignment is exact.
REQ-030 Disabled layer (enable=0) SHALL be transparent regardless of texel.
REQ-031 Scroll changes between vsync rising edges SHALL NOT affect output until next latch.
REQ-032 vsync_in rising while the pipeline holds in-flight pixels: in-flight pixels keep old scroll; new scroll applies from stage 0 on the latch cycle +1.

Reset
REQ-033 While rst=0: all pipeline registers, scroll registers, map_addr, tex_addr = 0; rgb_out = 0; hsync_out, vsync_out, frame_start = 0; hblank_out, vblank_out = 1.
REQ-034 Reset asserted mid-frame SHALL clear state immediately; after release, first valid pixel appears 4 cycles after its timing input; scroll = 0 until next vsync rise.

Verification
REQ-035 Map all tiles enabled, tex 1, texel=12'h0F0, scroll 0, hcount=0,vcount=0 -> rgb_out=12'h0F0 4 cycles later with aligned hsync_out.
REQ-036 LAYERS=2, layer1 texel=KEY_COLOR, layer0 texel=12'h00F -> rgb_out=12'h00F; layer1 texel=12'hF00 -> 12'hF00; both enable=0 -> BG_COLOR.
REQ-037 scroll_x=5 latched, hcount_in=1023 with map width 1024 px -> px=4, map_addr column 0, wraps correctly.
REQ-038 Change scroll_y mid-frame -> output unchanged until vsync_in rise; frame_start pulses exactly one cycle.
REQ-039 hflip=1, tile x=0 with TILE_LOG2=5 -> tex_addr tx field=31; vflip analogous on ty.
REQ-040 Assert rst low mid-line -> outputs at reset values asynchronously; release -> correct pixels resume after 4 cycles, blank -> rgb_out=0.
